// File: rtl/dma_host_agent_pkg.sv
// Shared definitions for the DMA host agent: host FSM states, 8237 register
// addresses used by benches and system tests, and the cycle-counter width.
package dmaRegConfigPkg;

  // Width of the data bus between host and controller.
  localparam int DATAWIDTH = 8;

  // Width of the shared up-counter used for STROBE and HOLD_WAIT timing.
  localparam int STROBE_CNT_W = 4;

  // Host agent FSM states.
  typedef enum logic [2:0] {
    H_IDLE      = 3'd0,
    H_SETUP     = 3'd1,
    H_STROBE    = 3'd2,
    H_RECOVER   = 3'd3,
    H_HOLD_WAIT = 3'd4,
    H_HELD      = 3'd5
  } hostState_t;

  // 8237 register map (A3..A0).
  localparam logic [3:0] REG_CH0_ADDR     = 4'h0;
  localparam logic [3:0] REG_CH0_COUNT    = 4'h1;
  localparam logic [3:0] REG_CH1_ADDR     = 4'h2;
  localparam logic [3:0] REG_CH1_COUNT    = 4'h3;
  localparam logic [3:0] REG_CH2_ADDR     = 4'h4;
  localparam logic [3:0] REG_CH2_COUNT    = 4'h5;
  localparam logic [3:0] REG_CH3_ADDR     = 4'h6;
  localparam logic [3:0] REG_CH3_COUNT    = 4'h7;
  localparam logic [3:0] REG_COMMAND      = 4'h8;  // write
  localparam logic [3:0] REG_STATUS       = 4'h8;  // read
  localparam logic [3:0] REG_REQUEST      = 4'h9;
  localparam logic [3:0] REG_MASK_SINGLE  = 4'hA;
  localparam logic [3:0] REG_MODE         = 4'hB;
  localparam logic [3:0] REG_CLEAR_FF     = 4'hC;
  localparam logic [3:0] REG_MASTER_CLEAR = 4'hD;
  localparam logic [3:0] REG_CLEAR_MASK   = 4'hE;
  localparam logic [3:0] REG_MASK_ALL     = 4'hF;

endpackage

// File: rtl/dma_host_agent.sv
// Host/CPU-side agent for the 8237-style DMA controller programming port.
// Converts a valid/ready command stream into CS_N/A/IOR_N/IOW_N/DB cycles and
// answers HRQ with HLDA, releasing the bus while the DMA owns it.
//
// Handshake: a command transfers on a rising CLK edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE with HRQ low, so at
// most one bus cycle is ever outstanding. rsp_valid is a one-cycle pulse in
// RECOVER for reads only, with no back-pressure.
//
// Optional build macro DMA_HOST_HOLD_STATS_EN adds hold_cycles[15:0], a
// saturating count of cycles with HLDA high, cleared only by RESET.
module dma_host_agent
  import dmaRegConfigPkg::*;
#(
  parameter int STROBE_CYCLES = 2,  // 1..15
  parameter int HLDA_DELAY    = 1   // 1..15
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [3:0]           cmd_addr,
  input  logic [DATAWIDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  input  logic                 HRQ,
  output logic                 HLDA,
  output logic                 CS_N,
  output logic                 IOR_N_o,
  output logic                 IOW_N_o,
  output logic                 io_oe,
`ifdef DMA_HOST_HOLD_STATS_EN
  output logic [15:0]          hold_cycles,
`endif
  output logic [3:0]           A_o,
  output logic [DATAWIDTH-1:0] DB_o,
  output logic                 db_oe,
  input  logic [DATAWIDTH-1:0] DB_i
);

  // Terminal counts: the counter starts at 0 on state entry, so the last
  // cycle of a phase is the one where it equals N-1.
  localparam logic [STROBE_CNT_W-1:0] STROBE_LAST = STROBE_CNT_W'(STROBE_CYCLES - 1);
  localparam logic [STROBE_CNT_W-1:0] HOLD_LAST   = STROBE_CNT_W'(HLDA_DELAY - 1);

  hostState_t                state_q;
  hostState_t                state_d;
  logic [STROBE_CNT_W-1:0]   cnt_q;
  logic                      write_q;
  logic [3:0]                addr_q;
  logic [DATAWIDTH-1:0]      wdata_q;
  logic [DATAWIDTH-1:0]      rdata_q;
  logic                      accept;

  // A command transfers only from IDLE while no hold is being requested.
  assign accept = (state_q == H_IDLE) && !HRQ && cmd_valid;

  // Next-state logic; HRQ wins over a simultaneous command in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      H_IDLE: begin
        if (HRQ)            state_d = H_HOLD_WAIT;
        else if (cmd_valid) state_d = H_SETUP;
      end
      H_SETUP:   state_d = H_STROBE;
      H_STROBE: begin
        if (cnt_q == STROBE_LAST) state_d = H_RECOVER;
      end
      H_RECOVER: state_d = H_IDLE;
      H_HOLD_WAIT: begin
        if (!HRQ)                   state_d = H_IDLE;
        else if (cnt_q == HOLD_LAST) state_d = H_HELD;
      end
      H_HELD: begin
        if (!HRQ) state_d = H_IDLE;
      end
      default: state_d = H_IDLE;
    endcase
  end

  // Bus and handshake outputs decoded from the current state.
  always_comb begin
    CS_N      = 1'b1;
    IOR_N_o   = 1'b1;
    IOW_N_o   = 1'b1;
    io_oe     = 1'b0;
    db_oe     = 1'b0;
    HLDA      = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      H_SETUP: begin
        CS_N  = 1'b0;
        io_oe = 1'b1;
        db_oe = write_q;
      end
      H_STROBE: begin
        CS_N    = 1'b0;
        io_oe   = 1'b1;
        db_oe   = write_q;
        IOW_N_o = !write_q;
        IOR_N_o = write_q;
      end
      H_RECOVER: begin
        CS_N      = 1'b0;
        io_oe     = 1'b1;
        rsp_valid = !write_q;
      end
      H_HELD: HLDA = 1'b1;
      default: ;
    endcase
  end

  // cmd_ready is forced low during reset so the reset value holds on the port.
  assign cmd_ready = (state_q == H_IDLE) && !HRQ && !RESET;
  assign A_o       = addr_q;
  assign DB_o      = wdata_q;
  assign rsp_rdata = rdata_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= H_IDLE;
    else       state_q <= state_d;
  end

  // Shared phase counter: clears on every state change, counts in timed states.
  always_ff @(posedge CLK) begin
    if (RESET || (state_d != state_q))
      cnt_q <= '0;
    else if ((state_q == H_STROBE) || (state_q == H_HOLD_WAIT))
      cnt_q <= cnt_q + 1'b1;
  end

  // Command capture on acceptance; held constant through the bus cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= cmd_write;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
    end
  end

  // Read data is sampled on the final strobe cycle while IOR_N is still low.
  always_ff @(posedge CLK) begin
    if (RESET)
      rdata_q <= '0;
    else if ((state_q == H_STROBE) && (cnt_q == STROBE_LAST) && !write_q)
      rdata_q <= DB_i;
  end

`ifdef DMA_HOST_HOLD_STATS_EN
  logic [15:0] hold_q;

  // Saturating count of cycles spent with HLDA asserted.
  always_ff @(posedge CLK) begin
    if (RESET)
      hold_q <= '0;
    else if ((state_q == H_HELD) && (hold_q != 16'hFFFF))
      hold_q <= hold_q + 16'd1;
  end

  assign hold_cycles = hold_q;
`endif

endmodule

// File: tb/tb_dma_host_agent.sv
// Self-checking bench for dma_host_agent: a bus device model answers register
// cycles, a reference register map predicts read data, and monitors compare
// responses and bus timing against the expected queues.
module tb_dma_host_agent;
  import dmaRegConfigPkg::*;

  localparam int S = 2;  // STROBE_CYCLES
  localparam int D = 3;  // HLDA_DELAY

  typedef struct packed {
    logic       w;
    logic [3:0] a;
    logic [7:0] d;
  } cmd_t;

  logic       clk = 1'b0;
  logic       RESET;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       HRQ, HLDA, CS_N, IOR_N_o, IOW_N_o, io_oe, db_oe;
  logic [3:0] A_o;
  logic [7:0] DB_o, DB_i;
`ifdef DMA_HOST_HOLD_STATS_EN
  logic [15:0] hold_cycles;
`endif

  int checks = 0;
  int errors = 0;
  logic abort = 1'b0;
  logic dev_clr = 1'b1;

  logic [7:0] ref_mem[16];
  logic [7:0] dev_mem[16];
  logic [7:0] exp_q[$];
  cmd_t       cmd_q[$];

  dma_host_agent #(.STROBE_CYCLES(S), .HLDA_DELAY(D)) dut (
    .CLK(clk), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .HRQ(HRQ), .HLDA(HLDA), .CS_N(CS_N), .IOR_N_o(IOR_N_o), .IOW_N_o(IOW_N_o),
    .io_oe(io_oe),
`ifdef DMA_HOST_HOLD_STATS_EN
    .hold_cycles(hold_cycles),
`endif
    .A_o(A_o), .DB_o(DB_o), .db_oe(db_oe), .DB_i(DB_i)
  );

  // Clock / device model
  always #5 clk = ~clk;

  // Device drives register contents only while IOR_N is low; otherwise the
  // complement, so a sample outside the strobe is visible.
  assign DB_i = (!CS_N && !IOR_N_o) ? dev_mem[A_o] : ~dev_mem[A_o];

  always @(posedge clk) begin
    if (dev_clr) begin
      for (int i = 0; i < 16; i++) dev_mem[i] <= 8'(i * 17);
    end else if (!RESET && !CS_N && !IOW_N_o && db_oe) begin
      dev_mem[A_o] <= DB_o;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register map updated in command order.
  task automatic note_accept(input logic w, input logic [3:0] a, input logic [7:0] d);
    cmd_t c;
    c.w = w; c.a = a; c.d = d;
    cmd_q.push_back(c);
    if (w) ref_mem[a] = d;
    else   exp_q.push_back(ref_mem[a]);
  endtask

  // Driver tasks
  task automatic do_cmd(input logic w, input logic [3:0] a, input logic [7:0] d);
    bit done = 0;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      #1;
      if (cmd_ready) begin
        note_accept(w, a, d);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        done = 1;
      end
    end
    if (!done) begin
      check("cmd_accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (cmd_ready) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_hlda(output int n);
    n = 0;
    while (!HLDA && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  // Scoreboard: read responses
  always @(negedge clk) begin
    #1;
    if (rsp_valid) begin
      if (exp_q.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
      else check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
    end
  end

  // Bus monitor: cycle shape, held fields, and release while held
  int   run = 0;
  cmd_t cur = '0;
  always @(negedge clk) begin
    logic win;
    #1;
    if (RESET || abort) begin
      run = 0;
    end else if (!CS_N) begin
      run++;
      if (run == 1) begin
        if (cmd_q.size() == 0) check("unexpected_cycle", 32'd1, 32'd0);
        else cur = cmd_q.pop_front();
      end
      win = (run >= 2) && (run <= S + 1);
      check("addr", 32'(A_o), 32'(cur.a));
      check("io_oe_cycle", 32'(io_oe), 32'd1);
      check("ready_busy", 32'(cmd_ready), 32'd0);
      check("hlda_busy", 32'(HLDA), 32'd0);
      check("iow", 32'(IOW_N_o), 32'(!(cur.w && win)));
      check("ior", 32'(IOR_N_o), 32'(!(!cur.w && win)));
      check("db_oe_cycle", 32'(db_oe), 32'(cur.w && run <= S + 1));
      if (cur.w && run <= S + 1) check("db_o", 32'(DB_o), 32'(cur.d));
    end else begin
      if (run != 0) check("cs_len", 32'(run), 32'(S + 2));
      run = 0;
      check("io_oe_idle", 32'(io_oe), 32'd0);
      check("db_oe_idle", 32'(db_oe), 32'd0);
      check("strobes_idle", 32'({IOR_N_o, IOW_N_o}), 32'd3);
      if (HLDA) check("ready_held", 32'(cmd_ready), 32'd0);
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Stimulus
  initial begin
    int n;
    RESET = 1'b1; HRQ = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 17);

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_hlda", 32'(HLDA), 32'd0);
    check("rst_cs_n", 32'(CS_N), 32'd1);
    check("rst_strobes", 32'({IOR_N_o, IOW_N_o}), 32'd3);
    check("rst_oe", 32'({io_oe, db_oe}), 32'd0);
    check("rst_a", 32'(A_o), 32'd0);
    check("rst_db", 32'(DB_o), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    RESET = 1'b0; dev_clr = 1'b0;

    // Directed write/read of the command/status register
    do_cmd(1'b1, REG_COMMAND, 8'h40);
    do_cmd(1'b0, REG_STATUS, 8'h00);
    do_cmd(1'b1, REG_COMMAND, 8'hA5);
    do_cmd(1'b0, REG_STATUS, 8'h00);

    // HRQ rises during STROBE of a write
    do_cmd(1'b1, 4'h6, 8'h77);
    @(negedge clk);
    @(negedge clk);
    HRQ = 1'b1;
    n = 0;
    while (!CS_N && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    wait_hlda(n);
    check("hlda_latency", 32'(n), 32'(D + 1));
    repeat (6) @(negedge clk);
    HRQ = 1'b0;
    @(negedge clk); #1;
    check("hlda_drop", 32'(HLDA), 32'd0);
    do_cmd(1'b0, 4'h6, 8'h00);

    // HRQ and cmd_valid together in IDLE: hold wins, command waits
    wait_idle();
    HRQ = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h3; cmd_wdata = 8'h3C;
    #1 check("ready_vs_hrq", 32'(cmd_ready), 32'd0);
    wait_hlda(n);
    check("hlda_granted", 32'(HLDA), 32'd1);
    repeat (4) begin
      @(negedge clk); #1;
      check("held_ready", 32'(cmd_ready), 32'd0);
    end
    HRQ = 1'b0;
    @(negedge clk); #1;
    check("hlda_drop2", 32'(HLDA), 32'd0);
    check("accept_after_hold", 32'(cmd_ready), 32'd1);
    note_accept(1'b1, 4'h3, 8'h3C);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    do_cmd(1'b0, 4'h3, 8'h00);

    // One-cycle HRQ pulse never reaches HLDA
    wait_idle();
    HRQ = 1'b1;
    @(negedge clk); #1;
    HRQ = 1'b0;
    check("pulse_hold_wait", 32'(cmd_ready), 32'd0);
    repeat (6) begin
      @(negedge clk); #1;
      check("pulse_no_hlda", 32'(HLDA), 32'd0);
    end
    check("pulse_back_idle", 32'(cmd_ready), 32'd1);

    // RESET during STROBE of a read abandons the cycle
    do_cmd(1'b0, 4'h5, 8'h00);
    @(negedge clk);
    @(negedge clk);
    RESET = 1'b1; abort = 1'b1;
    @(negedge clk); #1;
    check("abort_cs_n", 32'(CS_N), 32'd1);
    check("abort_strobes", 32'({IOR_N_o, IOW_N_o}), 32'd3);
    check("abort_rsp", 32'(rsp_valid), 32'd0);
    check("abort_oe", 32'({io_oe, db_oe}), 32'd0);
    check("abort_rdata", 32'(rsp_rdata), 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);
    abort = 1'b0;
`ifdef DMA_HOST_HOLD_STATS_EN
    check("stats_reset", 32'(hold_cycles), 32'd0);
    HRQ = 1'b1;
    wait_hlda(n);
    repeat (9) begin
      @(negedge clk); #1;
      check("stats_held", 32'(HLDA), 32'd1);
    end
    HRQ = 1'b0;
    @(negedge clk); #1;
    check("stats_hlda_drop", 32'(HLDA), 32'd0);
    check("hold_cycles", 32'(hold_cycles), 32'd10);
`endif

    // Randomized commands interleaved with HRQ bursts
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) < 2) begin
        @(negedge clk);
        HRQ = 1'b1;
        repeat ($urandom_range(1, 12)) @(negedge clk);
        HRQ = 1'b0;
      end else begin
        do_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int a = 0; a < 16; a++) do_cmd(1'b0, 4'(a), 8'h00);

    // Drain and report
    wait_idle();
    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
